// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and FSM state type shared by the seven-segment capture decoder
package seg7_pkg;

    // Segment patterns as {a,b,c,d,e,f,g}, a in the MSB
    localparam logic [6:0] GLYPH_0     = 7'h7E;
    localparam logic [6:0] GLYPH_1     = 7'h30;
    localparam logic [6:0] GLYPH_2     = 7'h6D;
    localparam logic [6:0] GLYPH_3     = 7'h79;
    localparam logic [6:0] GLYPH_4     = 7'h33;
    localparam logic [6:0] GLYPH_5     = 7'h5B;
    localparam logic [6:0] GLYPH_6     = 7'h5F;
    localparam logic [6:0] GLYPH_7     = 7'h70;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h7B;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h1F;
    localparam logic [6:0] GLYPH_C     = 7'h4E;
    localparam logic [6:0] GLYPH_D     = 7'h3D;
    localparam logic [6:0] GLYPH_E     = 7'h4F;
    localparam logic [6:0] GLYPH_F     = 7'h47;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } seg7_state_e;

endpackage

// File: rtl/seg7_capture_decoder_if.sv
// rtl/seg7_capture_decoder_if.sv - valid/ready result channel of the seven-segment capture decoder
interface seg7_capture_decoder_if;

    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nibble;
    logic       out_blank;
    logic       out_err;

    modport master (
        output out_valid,
        output out_nibble,
        output out_blank,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_nibble,
        input  out_blank,
        input  out_err,
        output out_ready
    );

endinterface

// File: rtl/seg7_glyph_lut.sv
// rtl/seg7_glyph_lut.sv - combinational segment-pattern to hex/blank/error decode
module seg7_glyph_lut
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    // Map a pattern to its hex digit; all-off is blank, anything unlisted is an error
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (pattern)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
            GLYPH_BLANK: blank  = 1'b1;
            default:     err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// rtl/seg7_capture_decoder.sv - debounced seven-segment capture with valid/ready result; SEG7_DEC_ERR_CNT_EN adds err_cnt
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic enable,
    seg7_capture_decoder_if.master out_if
`ifdef SEG7_DEC_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       pat_in;
    logic             changed;
    logic             handshake;

    logic [6:0]       pat_q,        pat_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             rep_q,        rep_d;
    seg7_state_e      state_q,      state_d;
    logic [3:0]       out_nibble_q, out_nibble_d;
    logic             out_blank_q,  out_blank_d;
    logic             out_err_q,    out_err_d;

    logic [3:0]       lut_nibble;
    logic             lut_blank;
    logic             lut_err;

    assign pat_in    = {a, b, c, d, e, f, g};
    assign changed   = (pat_in != pat_q);
    assign handshake = (state_q == ST_PRESENT) && out_if.out_ready;

    // pat_q equals the live input whenever a report can fire, so decode the registered copy
    seg7_glyph_lut u_lut (
        .pattern (pat_q),
        .nibble  (lut_nibble),
        .blank   (lut_blank),
        .err     (lut_err)
    );

    // Stability tracking plus the IDLE/PRESENT report handshake
    always_comb begin
        pat_d        = pat_q;
        cnt_d        = cnt_q;
        rep_d        = rep_q;
        state_d      = state_q;
        out_nibble_d = out_nibble_q;
        out_blank_d  = out_blank_q;
        out_err_d    = out_err_q;

        // Tracking keeps running while a result is waiting, so nothing stable is lost
        if (changed) begin
            pat_d = pat_in;
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && !changed && (cnt_q == CNT_MAX) && !rep_q) begin
                    state_d      = ST_PRESENT;
                    rep_d        = 1'b1;
                    out_nibble_d = lut_nibble;
                    out_blank_d  = lut_blank;
                    out_err_d    = lut_err;
                end
            end
            ST_PRESENT: begin
                if (out_if.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset wins over any pending handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q        <= '0;
            cnt_q        <= '0;
            rep_q        <= 1'b0;
            state_q      <= ST_IDLE;
            out_nibble_q <= 4'h0;
            out_blank_q  <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            pat_q        <= pat_d;
            cnt_q        <= cnt_d;
            rep_q        <= rep_d;
            state_q      <= state_d;
            out_nibble_q <= out_nibble_d;
            out_blank_q  <= out_blank_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_if.out_valid  = (state_q == ST_PRESENT);
    assign out_if.out_nibble = out_nibble_q;
    assign out_if.out_blank  = out_blank_q;
    assign out_if.out_err    = out_err_q;

`ifdef SEG7_DEC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count consumed error results, sticking at the top value
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (handshake && out_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: doc/seg7_capture_decoder.md
SEG7_CAPTURE_DECODER -- requirements
Module: seg7_capture_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples required before a pattern is decoded (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 8, width of the stability counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports a,b,c,d,e,f,g, input, 1 each, segment lines, active-high, with a as pattern MSB.
REQ-006 SHALL have port enable, input, 1, capture enable.
REQ-007 SHALL have port out_valid, output, 1, decoded result available.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-009 SHALL have port out_nibble, output, 4, decoded hex value.
REQ-010 SHALL have port out_blank, output, 1, the pattern was all segments off.
REQ-011 SHALL have port out_err, output, 1, the pattern is not a legal glyph.

Function
REQ-012 SHALL register pat_q = {a,b,c,d,e,f,g} every cycle when the input differs from pat_q, clear cnt to 0 and clear reported flag rep; otherwise it SHALL increment cnt, saturating at STABLE_CYCLES-1.
REQ-013 SHALL decode the glyph table 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, B=1F, C=4E, D=3D, E=4F, F=47 (hex of {a..g}) to out_nibble with out_err=0 and out_blank=0.
REQ-014 SHALL decode 7'h00 as out_blank=1, out_nibble=0, out_err=0; any other unlisted pattern SHALL produce out_err=1, out_nibble=0, out_blank=0.
REQ-015 SHALL implement FSM IDLE/PRESENT: IDLE->PRESENT when enable=1, cnt==STABLE_CYCLES-1, input==pat_q and rep=0; on this transition it SHALL latch the decode into the output registers and set rep=1.
REQ-016 SHALL give latency as follows: a pattern first sampled at edge E0 and held steady SHALL raise out_valid after edge E0+STABLE_CYCLES.
REQ-017 SHALL hold out_valid=1 and out_nibble/out_blank/out_err stable in PRESENT until out_valid&&out_ready; the handshake edge SHALL return the FSM to IDLE.
REQ-018 SHALL keep stability tracking running during PRESENT; a pattern that becomes stable during PRESENT SHALL be reported on the cycle after the handshake, with no loss.
REQ-019 SHALL report a stable pattern once only; the same pattern is reported again only after an intervening change (A->B->A reports A, B, A).
REQ-020 SHALL, when enable=0, block IDLE->PRESENT and hold cnt at 0; a PRESENT transfer already in progress SHALL still complete.
REQ-021 SHALL treat a one-cycle glitch as a change, which restarts the count.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set FSM=IDLE, out_valid=0, out_nibble=0, out_blank=0, out_err=0, pat_q=0, cnt=0, rep=0; reset overrides every other event, including a pending handshake.
REQ-023 SHALL treat reset mid-PRESENT as dropping the result; an unchanged pattern after reset SHALL be re-reported after the full stability window.

Configuration
REQ-024 SHALL, with macro SEG7_DEC_ERR_CNT_EN defined, add output err_cnt[7:0], reset to 0, incremented on each handshake where out_err=1 and saturating at 255.
REQ-025 SHALL, without SEG7_DEC_ERR_CNT_EN, omit the err_cnt port and its counter entirely; all other behaviour SHALL be identical.

Structure
REQ-026 SHALL place the 16 glyph constants, the blank constant and the FSM state enum in shared package seg7_pkg.
REQ-027 SHALL implement decoding in combinational sub-module seg7_glyph_lut (7-bit pattern in; nibble, blank and err out), instantiated once.

Verification
REQ-028 SHALL cover: STABLE_CYCLES=4, hold 7'h6D, out_ready=1 -> out_valid rises after the 4th edge following capture, with nibble=2 and err=0; pattern held thereafter -> no second report.
REQ-029 SHALL cover: 7'h00 held -> blank=1, nibble=0; then 7'h12 held -> err=1, nibble=0 (and err_cnt=1 when the macro is enabled).
REQ-030 SHALL cover: 7'h30 with a 1-cycle glitch to 7'h7F at cycle 2 -> no report of 7'h7F, and 1 reported 4 edges after the glitch ends.
REQ-031 SHALL cover: out_ready=0 while reporting 7'h79, then input changes to 7'h33 -> output holds 3; raising out_ready reports 4 on the next cycle.
REQ-032 SHALL cover: enable=0 with 7'h4F stable -> no out_valid; enable=1 -> out_valid after 4 edges, nibble=E.
REQ-033 SHALL cover: rst pulsed while PRESENT holds 7'h7B -> all outputs 0 next cycle; 7'h7B re-reported 4 edges after rst falls.
